// File: rtl/vga_timing_probe.sv
// Receive-side VGA sync analyser: detects sync polarity, measures line/frame timing,
// tracks frame-to-frame stability and presents one selected field for a hex display.
module vga_timing_probe #(
    parameter int TIMEOUT     = 65535,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [1:0]  sel,
    output logic [15:0] result,
    output logic        valid,
    output logic        locked,
    output logic        hsync_pol,
    output logic        vsync_pol
);

    localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);
    localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEEK, H_POL, V_POL, MEAS} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t      state_r;
    logic        hs_meta_r, hs_sync_r, hs_prev_r;
    logic        vs_meta_r, vs_sync_r, vs_prev_r;
    logic [15:0] h_cnt_r, to_cnt_r, line_cnt_r, vp_cnt_r;
    logic [15:0] h_total_cur_r, h_pulse_cur_r, first_dur_r;
    logic        first_lvl_r, meas_armed_r;
    logic [1:0]  edge_cnt_r;
    logic [15:0] h_total_r, h_pulse_r, v_total_r, v_pulse_r;
    logic [3:0]  match_r;

    logic        hs_edge_s, hs_act_s, hs_inact_s, vs_edge_s, vs_act_s;
    logic        timeout_s, latch_s, frame_eq_s;
    logic [15:0] line_nx_s, vp_nx_s, htot_nx_s, hpul_nx_s;
    logic [15:0] f_htot_s, f_hpul_s, f_vtot_s, f_vpul_s, result_s;
    logic [15:0] hi_dur_s, lo_dur_s;
    logic [3:0]  match_nx_s;

    assign hs_edge_s  = hs_sync_r ^ hs_prev_r;
    assign hs_act_s   = hs_edge_s & (hs_sync_r == hsync_pol);
    assign hs_inact_s = hs_edge_s & (hs_sync_r != hsync_pol);
    assign vs_edge_s  = vs_sync_r ^ vs_prev_r;
    assign vs_act_s   = vs_edge_s & (vs_sync_r == vsync_pol);

    assign timeout_s  = (state_r != SEEK) && (to_cnt_r >= TIMEOUT_C);
    assign latch_s    = (state_r == MEAS) && vs_act_s && meas_armed_r && !timeout_s;

    // Line counted before the frame closes, so a coincident hsync lands in this frame
    assign line_nx_s  = hs_act_s ? sat_inc(line_cnt_r) : line_cnt_r;
    assign vp_nx_s    = (hs_act_s && (vs_sync_r == vsync_pol)) ? sat_inc(vp_cnt_r) : vp_cnt_r;
    assign htot_nx_s  = hs_act_s ? h_cnt_r : h_total_cur_r;
    assign hpul_nx_s  = hs_inact_s ? h_cnt_r : h_pulse_cur_r;

    assign f_htot_s   = latch_s ? htot_nx_s : h_total_r;
    assign f_hpul_s   = latch_s ? hpul_nx_s : h_pulse_r;
    assign f_vtot_s   = latch_s ? line_nx_s : v_total_r;
    assign f_vpul_s   = latch_s ? vp_nx_s   : v_pulse_r;

    assign frame_eq_s = (htot_nx_s == h_total_r) && (hpul_nx_s == h_pulse_r) &&
                        (line_nx_s == v_total_r) && (vp_nx_s == v_pulse_r);

    assign match_nx_s = timeout_s ? 4'd0 :
                        !latch_s  ? match_r :
                        !frame_eq_s ? 4'd1 :
                        (match_r == 4'hF) ? match_r : match_r + 4'd1;

    // Second H_POL interval is at the opposite level of the first
    assign hi_dur_s   = first_lvl_r ? first_dur_r : h_cnt_r;
    assign lo_dur_s   = first_lvl_r ? h_cnt_r : first_dur_r;

    // Display field select, fed from the values the result registers will hold
    always_comb begin
        result_s = 16'd0;
        case (sel)
            2'd0:    result_s = f_htot_s;
            2'd1:    result_s = f_hpul_s;
            2'd2:    result_s = f_vtot_s;
            2'd3:    result_s = f_vpul_s;
            default: result_s = 16'd0;
        endcase
    end

    // Synchronizers, measurement FSM, frame results and registered outputs
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_r <= SEEK;
            {hs_meta_r, hs_sync_r, hs_prev_r} <= 3'b000;
            {vs_meta_r, vs_sync_r, vs_prev_r} <= 3'b000;
            h_cnt_r <= 16'd0;        to_cnt_r <= 16'd0;
            line_cnt_r <= 16'd0;     vp_cnt_r <= 16'd0;
            h_total_cur_r <= 16'd0;  h_pulse_cur_r <= 16'd0;
            first_dur_r <= 16'd0;    first_lvl_r <= 1'b0;
            meas_armed_r <= 1'b0;    edge_cnt_r <= 2'd0;
            h_total_r <= 16'd0;      h_pulse_r <= 16'd0;
            v_total_r <= 16'd0;      v_pulse_r <= 16'd0;
            match_r <= 4'd0;
            result <= 16'd0;         valid <= 1'b0;
            locked <= 1'b0;          hsync_pol <= 1'b0;
            vsync_pol <= 1'b0;
        end else begin
            {hs_meta_r, hs_sync_r, hs_prev_r} <= {hsync_in, hs_meta_r, hs_sync_r};
            {vs_meta_r, vs_sync_r, vs_prev_r} <= {vsync_in, vs_meta_r, vs_sync_r};
            to_cnt_r  <= hs_edge_s ? 16'd0 : sat_inc(to_cnt_r);
            valid     <= latch_s;
            match_r   <= match_nx_s;
            locked    <= (match_nx_s >= LOCK_C);
            h_total_r <= f_htot_s;
            h_pulse_r <= f_hpul_s;
            v_total_r <= f_vtot_s;
            v_pulse_r <= f_vpul_s;
            result    <= result_s;
            if (timeout_s) begin
                state_r <= SEEK;
            end else begin
                case (state_r)
                    SEEK: begin
                        if (hs_edge_s) begin
                            state_r    <= H_POL;
                            edge_cnt_r <= 2'd0;
                            h_cnt_r    <= 16'd0;
                        end
                    end
                    H_POL: begin
                        h_cnt_r <= sat_inc(h_cnt_r);
                        if (hs_edge_s) begin
                            h_cnt_r <= 16'd1;
                            case (edge_cnt_r)
                                2'd0: edge_cnt_r <= 2'd1;
                                2'd1: begin
                                    first_dur_r <= h_cnt_r;
                                    first_lvl_r <= hs_prev_r;
                                    edge_cnt_r  <= 2'd2;
                                end
                                default: begin
                                    hsync_pol  <= (hi_dur_s < lo_dur_s);
                                    state_r    <= V_POL;
                                    edge_cnt_r <= 2'd0;
                                    line_cnt_r <= 16'd0;
                                    vp_cnt_r   <= 16'd0;
                                end
                            endcase
                        end
                    end
                    V_POL: begin
                        h_cnt_r <= hs_act_s ? 16'd1 : sat_inc(h_cnt_r);
                        // line_cnt holds lines seen with vsync high, vp_cnt with vsync low
                        if (hs_act_s && (edge_cnt_r != 2'd0)) begin
                            if (vs_sync_r) begin
                                line_cnt_r <= sat_inc(line_cnt_r);
                            end else begin
                                vp_cnt_r <= sat_inc(vp_cnt_r);
                            end
                        end
                        if (vs_edge_s) begin
                            case (edge_cnt_r)
                                2'd0: edge_cnt_r <= 2'd1;
                                2'd1: edge_cnt_r <= 2'd2;
                                default: begin
                                    vsync_pol    <= (line_cnt_r < vp_cnt_r);
                                    state_r      <= MEAS;
                                    meas_armed_r <= 1'b0;
                                    line_cnt_r   <= 16'd0;
                                    vp_cnt_r     <= 16'd0;
                                end
                            endcase
                        end
                    end
                    MEAS: begin
                        h_cnt_r       <= hs_act_s ? 16'd1 : sat_inc(h_cnt_r);
                        h_total_cur_r <= htot_nx_s;
                        h_pulse_cur_r <= hpul_nx_s;
                        if (vs_act_s) begin
                            line_cnt_r   <= 16'd0;
                            vp_cnt_r     <= 16'd0;
                            meas_armed_r <= 1'b1;
                        end else begin
                            line_cnt_r <= line_nx_s;
                            vp_cnt_r   <= vp_nx_s;
                        end
                    end
                    default: state_r <= SEEK;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_probe.sv
// Scoreboard bench for vga_timing_probe: directed scaled-down sync streams with
// hand-computed frame results, checked by a monitor on every valid pulse.
module tb_vga_timing_probe;
    localparam int TO = 300;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic [1:0]  sel = 2'd0;
    logic [15:0] result;
    logic        valid, locked, hsync_pol, vsync_pol;

    vga_timing_probe #(.TIMEOUT(TO), .LOCK_FRAMES(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .sel(sel), .result(result), .valid(valid), .locked(locked),
        .hsync_pol(hsync_pol), .vsync_pol(vsync_pol)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic        lk;
        logic        hp;
        logic        vp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    bit   quiet = 1'b0;

    int s_len, s_hp, s_lines, s_vl, s_voff;
    bit s_inv;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h want 0x%04h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_result"}, result, 16'h0000);
        chk1({tag, "_valid"}, valid, 1'b0);
        chk1({tag, "_locked"}, locked, 1'b0);
        chk1({tag, "_hpol"}, hsync_pol, 1'b0);
        chk1({tag, "_vpol"}, vsync_pol, 1'b0);
    endtask

    // Monitor: every valid pops the next expected frame; valids inside a quiet window are errors
    always @(negedge sys_clk) begin
        if (sys_rst_n && valid === 1'b1) begin
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk($sformatf("item%0d_result", e.id), result, e.res);
                chk1($sformatf("item%0d_locked", e.id), locked, e.lk);
                chk1($sformatf("item%0d_hpol", e.id), hsync_pol, e.hp);
                chk1($sformatf("item%0d_vpol", e.id), vsync_pol, e.vp);
            end else if (quiet) begin
                total++;
                bad++;
                $display("FAIL early_valid: got valid=1 want 0 inside quiet window");
            end
        end
    end

    task automatic push(input int id, input logic [15:0] r, input logic lk,
                        input logic hp, input logic vp);
        exp_t e;
        e = '{id, r, lk, hp, vp};
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk); #1;
            hsync_in = !s_inv;
            vsync_in = !s_inv;
        end
    endtask

    task automatic do_reset();
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        hsync_in  = !s_inv;
        vsync_in  = !s_inv;
        @(posedge sys_clk); #1;
        check_zero("reset");
        sys_rst_n = 1'b1;
    endtask

    // One frame: hsync pulse at line start, vsync changes at cycle s_voff of its line
    task automatic run_frame(input int rst_line);
        bit rp;
        rp = 1'b0;
        for (int l = 0; l < s_lines; l++) begin
            for (int c = 0; c < s_len; c++) begin
                int vidx;
                bit hpl, vpl;
                @(posedge sys_clk); #1;
                if (rp) begin
                    check_zero("midframe_rst");
                    sys_rst_n = 1'b1;
                    quiet = 1'b1;
                    rp = 1'b0;
                end
                hpl  = (c < s_hp);
                vidx = (c >= s_voff) ? l : l - 1;
                vpl  = (vidx >= 0) && (vidx < s_vl);
                hsync_in = hpl ? s_inv : !s_inv;
                vsync_in = vpl ? s_inv : !s_inv;
                if (l == rst_line && c == 0) begin
                    sys_rst_n = 1'b0;
                    rp = 1'b1;
                end
            end
        end
    endtask

    task automatic run_until_pop(input int maxf);
        for (int f = 0; f < maxf && exp_q.size() > 0; f++) run_frame(-1);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL pop_timeout: pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        s_len = 40; s_hp = 6; s_lines = 20; s_vl = 3; s_voff = 20; s_inv = 1'b0;

        repeat (2) @(posedge sys_clk);
        #1;
        check_zero("por");
        sys_rst_n = 1'b1;
        idle(5);

        // Nominal active-low stream: 40 clk lines, 6 clk hsync, 20 lines, 3 vsync lines
        sel = 2'd0; push(1, 16'h0028, 1'b0, 1'b0, 1'b0); run_until_pop(8);
        push(2, 16'h0028, 1'b1, 1'b0, 1'b0); run_until_pop(2);
        sel = 2'd1; push(3, 16'h0006, 1'b1, 1'b0, 1'b0); run_until_pop(2);
        sel = 2'd2; push(4, 16'h0014, 1'b1, 1'b0, 1'b0); run_until_pop(2);
        sel = 2'd3; push(5, 16'h0003, 1'b1, 1'b0, 1'b0); run_until_pop(2);

        // Line period change to 44 after lock
        sel = 2'd0; s_len = 44;
        push(6, 16'h0028, 1'b1, 1'b0, 1'b0); run_until_pop(2);
        push(7, 16'h002C, 1'b0, 1'b0, 1'b0); run_until_pop(2);
        push(8, 16'h002C, 1'b1, 1'b0, 1'b0); run_until_pop(2);

        // Signal loss, held results, then re-lock
        idle(TO + 10);
        chk1("loss_locked", locked, 1'b0);
        chk("loss_result_htot", result, 16'h002C);
        sel = 2'd3;
        idle(2);
        chk("loss_result_vpul", result, 16'h0003);
        sel = 2'd0;
        push(9, 16'h002C, 1'b0, 1'b0, 1'b0); run_until_pop(8);
        push(10, 16'h002C, 1'b1, 1'b0, 1'b0); run_until_pop(2);

        // Inverted syncs
        s_len = 40; s_inv = 1'b1;
        do_reset();
        idle(5);
        push(11, 16'h0028, 1'b0, 1'b1, 1'b1); run_until_pop(8);
        push(12, 16'h0028, 1'b1, 1'b1, 1'b1); run_until_pop(2);
        sel = 2'd1; push(13, 16'h0006, 1'b1, 1'b1, 1'b1); run_until_pop(2);
        sel = 2'd2; push(14, 16'h0014, 1'b1, 1'b1, 1'b1); run_until_pop(2);
        sel = 2'd3; push(15, 16'h0003, 1'b1, 1'b1, 1'b1); run_until_pop(2);

        // One-cycle reset mid-frame, no valid for the following two frames
        sel = 2'd0;
        run_frame(10);
        run_frame(-1);
        run_frame(-1);
        quiet = 1'b0;
        push(16, 16'h0028, 1'b0, 1'b1, 1'b1); run_until_pop(6);
        push(17, 16'h0028, 1'b1, 1'b1, 1'b1); run_until_pop(2);

        // Coincident hsync/vsync active edges, 666 lines per frame
        s_len = 4; s_hp = 1; s_lines = 666; s_vl = 6; s_voff = 0; s_inv = 1'b0;
        do_reset();
        idle(5);
        sel = 2'd2;
        push(18, 16'h029A, 1'b0, 1'b0, 1'b0); run_until_pop(8);
        push(19, 16'h029A, 1'b1, 1'b0, 1'b0); run_until_pop(2);
        sel = 2'd3;
        push(20, 16'h0006, 1'b1, 1'b0, 1'b0); run_until_pop(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
